// File: rtl/wrb_port_arbiter_pkg.sv
// Shared types for the register-file writeback port arbiter.
// The arbiter FSM states are plain constants so older tools can consume them.
package wrb_port_arbiter_pkg;

    localparam int unsigned XLEN_DEF    = 32;
    localparam int unsigned RADDR_W_DEF = 5;

    typedef struct packed {
        logic [RADDR_W_DEF-1:0] rd_addr;
        logic [XLEN_DEF-1:0]    rd_data;
    } type_wrb_req_s;

    typedef logic [0:0] type_wrb_arb_state_e;

    localparam type_wrb_arb_state_e PIPE_PRI  = 1'b0;
    localparam type_wrb_arb_state_e FORCE_MDU = 1'b1;

endpackage

// File: rtl/wrb_mdu_fifo.sv
// Small FIFO for MDU writeback results.
// Each entry carries a live bit so a younger pipeline write to the same rd can kill it in place.
module wrb_mdu_fifo
    import wrb_port_arbiter_pkg::*;
#(
    parameter int unsigned XLEN    = XLEN_DEF,
    parameter int unsigned RADDR_W = RADDR_W_DEF,
    parameter int unsigned DEPTH   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [RADDR_W-1:0]         push_addr,
    input  logic [XLEN-1:0]            push_data,
    input  logic                       pop,
    input  logic                       kill,
    input  logic [RADDR_W-1:0]         kill_addr,
    input  logic [RADDR_W-1:0]         rs1_addr,
    input  logic [RADDR_W-1:0]         rs2_addr,
    output logic                       head_valid,
    output logic                       head_live,
    output logic [RADDR_W-1:0]         head_addr,
    output logic [XLEN-1:0]            head_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       any_live,
    output logic                       rs1_hit,
    output logic                       rs2_hit
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [RADDR_W-1:0] addr_q [DEPTH];
    logic [XLEN-1:0]    data_q [DEPTH];
    logic [DEPTH-1:0]   live_q, live_d;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q;

    assign head_valid = count_q != '0;
    assign head_live  = live_q[rd_ptr_q];
    assign head_addr  = addr_q[rd_ptr_q];
    assign head_data  = data_q[rd_ptr_q];
    assign count      = count_q;
    assign any_live   = |live_q;

    // A push killed by a same-cycle pipeline write to the same rd enters already dead.
    always_comb begin
        live_d = live_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (kill && addr_q[i] == kill_addr) begin
                live_d[i] = 1'b0;
            end
        end
        if (pop) begin
            live_d[rd_ptr_q] = 1'b0;
        end
        if (push) begin
            live_d[wr_ptr_q] = !(kill && push_addr == kill_addr);
        end
    end

    always_comb begin
        rs1_hit = 1'b0;
        rs2_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i] && addr_q[i] == rs1_addr) rs1_hit = 1'b1;
            if (live_q[i] && addr_q[i] == rs2_addr) rs2_hit = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            live_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            live_q <= live_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr_q] <= push_addr;
            data_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/wrb_port_arbiter.sv
// Arbitrates the single register-file write port between pipeline writeback and buffered MDU
// results, with a bounded-wait forced MDU slot and pending-hit flags for the stall unit.
module wrb_port_arbiter
    import wrb_port_arbiter_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEF,
    parameter int unsigned RADDR_W  = RADDR_W_DEF,
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pipe_valid_i,
    input  logic [RADDR_W-1:0] pipe_rd_addr_i,
    input  logic [XLEN-1:0]    pipe_rd_data_i,
    output logic               pipe_stall_o,
    input  logic               mdu_valid_i,
    input  logic [RADDR_W-1:0] mdu_rd_addr_i,
    input  logic [XLEN-1:0]    mdu_rd_data_i,
    output logic               mdu_ready_o,
    input  logic [RADDR_W-1:0] rs1_addr_i,
    input  logic [RADDR_W-1:0] rs2_addr_i,
    output logic               pend_rs1_o,
    output logic               pend_rs2_o,
    output logic               rf_wr_req_o,
    output logic [RADDR_W-1:0] rf_rd_addr_o,
    output logic [XLEN-1:0]    rf_rd_data_o
);
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
    localparam int unsigned WAIT_W = $clog2(MAX_WAIT) + 1;

    type_wrb_arb_state_e state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;

    logic               head_valid, head_live, any_live, rs1_hit, rs2_hit;
    logic [RADDR_W-1:0] head_addr;
    logic [XLEN-1:0]    head_data;
    logic [CNT_W-1:0]   count;

    logic               mdu_push, mdu_grant, pipe_write, fifo_pop;
    logic               rf_wr_req_d;
    logic [RADDR_W-1:0] rf_rd_addr_d;
    logic [XLEN-1:0]    rf_rd_data_d;

    assign mdu_ready_o = count < CNT_W'(DEPTH);
    assign mdu_push    = mdu_valid_i & mdu_ready_o & (mdu_rd_addr_i != '0);

    wrb_mdu_fifo #(
        .XLEN    (XLEN),
        .RADDR_W (RADDR_W),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (mdu_push),
        .push_addr  (mdu_rd_addr_i),
        .push_data  (mdu_rd_data_i),
        .pop        (fifo_pop),
        .kill       (pipe_write),
        .kill_addr  (pipe_rd_addr_i),
        .rs1_addr   (rs1_addr_i),
        .rs2_addr   (rs2_addr_i),
        .head_valid (head_valid),
        .head_live  (head_live),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .count      (count),
        .any_live   (any_live),
        .rs1_hit    (rs1_hit),
        .rs2_hit    (rs2_hit)
    );

    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        mdu_grant    = 1'b0;
        pipe_stall_o = 1'b0;
        if (state_q == FORCE_MDU) begin
            // One forced slot per trigger; an x0 pipe request is still accepted alongside it.
            mdu_grant    = head_live;
            pipe_stall_o = pipe_valid_i & (pipe_rd_addr_i != '0);
            wait_d       = '0;
            state_d      = PIPE_PRI;
        end else begin
            mdu_grant = !pipe_valid_i & head_live;
            if (head_live && !mdu_grant) begin
                wait_d = wait_q + WAIT_W'(1);
                if (wait_q == WAIT_W'(MAX_WAIT - 1) || count == CNT_W'(DEPTH)) begin
                    state_d = FORCE_MDU;
                end
            end
            if (mdu_grant || !any_live) begin
                wait_d = '0;
            end
        end
        pipe_write = pipe_valid_i & (pipe_rd_addr_i != '0) & !pipe_stall_o;
        fifo_pop   = head_valid & (mdu_grant | !head_live);
    end

    always_comb begin
        rf_wr_req_d  = 1'b0;
        rf_rd_addr_d = '0;
        rf_rd_data_d = '0;
        if (mdu_grant) begin
            rf_wr_req_d  = 1'b1;
            rf_rd_addr_d = head_addr;
            rf_rd_data_d = head_data;
        end else if (pipe_write) begin
            rf_wr_req_d  = 1'b1;
            rf_rd_addr_d = pipe_rd_addr_i;
            rf_rd_data_d = pipe_rd_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= PIPE_PRI;
            wait_q       <= '0;
            rf_wr_req_o  <= 1'b0;
            rf_rd_addr_o <= '0;
            rf_rd_data_o <= '0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            rf_wr_req_o  <= rf_wr_req_d;
            rf_rd_addr_o <= rf_rd_addr_d;
            rf_rd_data_o <= rf_rd_data_d;
        end
    end

    assign pend_rs1_o = (rs1_addr_i != '0) &
                        (rs1_hit | (rf_wr_req_o & (rf_rd_addr_o == rs1_addr_i)));
    assign pend_rs2_o = (rs2_addr_i != '0) &
                        (rs2_hit | (rf_wr_req_o & (rf_rd_addr_o == rs2_addr_i)));

endmodule

// File: tb/tb_wrb_port_arbiter.sv
// Self-checking bench for wrb_port_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_wrb_port_arbiter;
    localparam int DEPTH    = 2;
    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pipe_valid = 1'b0;
    logic [4:0]  pipe_rd_addr = '0;
    logic [31:0] pipe_rd_data = '0;
    logic        pipe_stall;
    logic        mdu_valid = 1'b0;
    logic [4:0]  mdu_rd_addr = '0;
    logic [31:0] mdu_rd_data = '0;
    logic        mdu_ready;
    logic [4:0]  rs1_addr = '0;
    logic [4:0]  rs2_addr = '0;
    logic        pend_rs1, pend_rs2;
    logic        rf_wr_req;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_rd_data;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wrb_port_arbiter #(
        .XLEN     (32),
        .RADDR_W  (5),
        .DEPTH    (DEPTH),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pipe_valid_i   (pipe_valid),
        .pipe_rd_addr_i (pipe_rd_addr),
        .pipe_rd_data_i (pipe_rd_data),
        .pipe_stall_o   (pipe_stall),
        .mdu_valid_i    (mdu_valid),
        .mdu_rd_addr_i  (mdu_rd_addr),
        .mdu_rd_data_i  (mdu_rd_data),
        .mdu_ready_o    (mdu_ready),
        .rs1_addr_i     (rs1_addr),
        .rs2_addr_i     (rs2_addr),
        .pend_rs1_o     (pend_rs1),
        .pend_rs2_o     (pend_rs2),
        .rf_wr_req_o    (rf_wr_req),
        .rf_rd_addr_o   (rf_rd_addr),
        .rf_rd_data_o   (rf_rd_data)
    );

    // Reference model: oldest-first queue of buffered MDU results plus the registered write.
    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        bit          live;
    } ent_t;

    ent_t        mq[$];
    bit          m_force = 0;
    int          m_wait = 0;
    bit          m_req = 0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;

    bit          e_stall, e_ready, e_pend1, e_pend2;
    logic        a_stall, a_ready, a_pend1, a_pend2, a_req;
    logic [4:0]  a_addr;
    logic [31:0] a_data;

    function automatic bit pend_of(input logic [4:0] rs);
        if (rs == 5'd0) return 1'b0;
        if (m_req && m_addr == rs) return 1'b1;
        foreach (mq[i]) if (mq[i].live && mq[i].a == rs) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_comb();
        e_ready = mq.size() < DEPTH;
        e_stall = m_force && pipe_valid && pipe_rd_addr != 5'd0;
        e_pend1 = pend_of(rs1_addr);
        e_pend2 = pend_of(rs2_addr);
    endtask

    task automatic model_clock();
        bit hl, mg, pw, live_any, rdy;
        int n;
        if (rst) begin
            mq.delete();
            m_force = 0; m_wait = 0; m_req = 0; m_addr = '0; m_data = '0;
            return;
        end
        n = mq.size();
        hl = n > 0 && mq[0].live;
        live_any = 0;
        foreach (mq[i]) if (mq[i].live) live_any = 1;
        rdy = n < DEPTH;
        mg = m_force ? hl : (!pipe_valid && hl);
        pw = pipe_valid && pipe_rd_addr != 5'd0 && !m_force;
        if (mg) begin
            m_req = 1; m_addr = mq[0].a; m_data = mq[0].d;
        end else if (pw) begin
            m_req = 1; m_addr = pipe_rd_addr; m_data = pipe_rd_data;
        end else begin
            m_req = 0; m_addr = '0; m_data = '0;
        end
        if (m_force) begin
            m_force = 0; m_wait = 0;
        end else begin
            if (hl && !mg) begin
                if (m_wait == MAX_WAIT - 1 || n == DEPTH) m_force = 1;
                m_wait++;
            end
            if (mg || !live_any) m_wait = 0;
        end
        if (n > 0 && (mg || !mq[0].live)) void'(mq.pop_front());
        if (pw) foreach (mq[i]) if (mq[i].a == pipe_rd_addr) mq[i].live = 0;
        if (mdu_valid && rdy && mdu_rd_addr != 5'd0)
            mq.push_back('{mdu_rd_addr, mdu_rd_data, !(pw && pipe_rd_addr == mdu_rd_addr)});
    endtask

    // Drive one cycle; combinational outputs sampled mid-low phase, rf_* just after the edge.
    task automatic cycle(input bit r, input bit pv, input logic [4:0] pa, input logic [31:0] pd,
                         input bit mv, input logic [4:0] ma, input logic [31:0] md,
                         input logic [4:0] r1, input logic [4:0] r2);
        @(negedge clk);
        rst = r; pipe_valid = pv; pipe_rd_addr = pa; pipe_rd_data = pd;
        mdu_valid = mv; mdu_rd_addr = ma; mdu_rd_data = md; rs1_addr = r1; rs2_addr = r2;
        #1;
        model_comb();
        a_stall = pipe_stall; a_ready = mdu_ready; a_pend1 = pend_rs1; a_pend2 = pend_rs2;
        @(posedge clk);
        model_clock();
        #1;
        a_req = rf_wr_req; a_addr = rf_rd_addr; a_data = rf_rd_data;
    endtask

    task automatic idle(input logic [4:0] r1);
        cycle(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, r1, 5'd0);
    endtask

    task automatic test_reset();
        cycle(1, 1, 5'd5, 32'h1234, 1, 5'd6, 32'h5678, 5'd5, 5'd6);
        cycle(1, 1, 5'd5, 32'h1234, 1, 5'd6, 32'h5678, 5'd5, 5'd6);
        checks++; if (a_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %0d want 0", a_req); end
        checks++; if (a_addr !== 5'd0) begin failures++; $display("FAIL reset_addr: got %0d want 0", a_addr); end
        checks++; if (a_data !== 32'd0) begin failures++; $display("FAIL reset_data: got %0h want 0", a_data); end
        cycle(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd5, 5'd6);
        checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %0d want 1", a_ready); end
        checks++; if (a_stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %0d want 0", a_stall); end
        checks++; if (a_pend1 !== 1'b0 || a_pend2 !== 1'b0) begin
            failures++; $display("FAIL reset_pend: got %0d%0d want 00", a_pend1, a_pend2); end
    endtask

    task automatic test_pipe_only();
        for (int i = 0; i < 10; i++) begin
            cycle(0, 1, 5'd5, 32'h11, 0, 5'd0, 32'd0, 5'd0, 5'd0);
            checks++; if (a_stall !== 1'b0) begin failures++; $display("FAIL pipe_only_stall[%0d]: got %0d want 0", i, a_stall); end
            checks++; if (a_req !== 1'b1 || a_addr !== 5'd5 || a_data !== 32'h11) begin
                failures++; $display("FAIL pipe_only_wr[%0d]: got %0d/x%0d/%0h want 1/x5/11", i, a_req, a_addr, a_data); end
        end
    endtask

    task automatic test_mdu_idle();
        cycle(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd0, 5'd0);
        cycle(0, 0, 5'd0, 32'd0, 1, 5'd7, 32'hABCD, 5'd7, 5'd0);
        checks++; if (a_pend1 !== 1'b0) begin failures++; $display("FAIL mdu_idle_pend_push: got %0d want 0", a_pend1); end
        checks++; if (a_req !== 1'b0) begin failures++; $display("FAIL mdu_idle_early_wr: got %0d want 0", a_req); end
        idle(5'd7);
        checks++; if (a_pend1 !== 1'b1) begin failures++; $display("FAIL mdu_idle_pend_fifo: got %0d want 1", a_pend1); end
        checks++; if (a_req !== 1'b1 || a_addr !== 5'd7 || a_data !== 32'hABCD) begin
            failures++; $display("FAIL mdu_idle_wr: got %0d/x%0d/%0h want 1/x7/abcd", a_req, a_addr, a_data); end
        idle(5'd7);
        checks++; if (a_pend1 !== 1'b1) begin failures++; $display("FAIL mdu_idle_pend_rf: got %0d want 1", a_pend1); end
        idle(5'd7);
        checks++; if (a_pend1 !== 1'b0) begin failures++; $display("FAIL mdu_idle_pend_done: got %0d want 0", a_pend1); end
    endtask

    task automatic test_starvation();
        logic [4:0] pa;
        cycle(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd0, 5'd0);
        for (int k = 0; k <= 6; k++) begin
            pa = (k <= 5) ? 5'(k + 1) : 5'd6;
            cycle(0, 1, pa, 32'(100 + k), k == 0, 5'd9, 32'h99, 5'd0, 5'd0);
            checks++; if (a_stall !== (k == 5)) begin
                failures++; $display("FAIL starve_stall[%0d]: got %0d want %0d", k, a_stall, k == 5); end
            if (k == 5) begin
                checks++; if (a_req !== 1'b1 || a_addr !== 5'd9 || a_data !== 32'h99) begin
                    failures++; $display("FAIL starve_forced_wr: got %0d/x%0d/%0h want 1/x9/99", a_req, a_addr, a_data); end
            end
            if (k == 6) begin
                checks++; if (a_req !== 1'b1 || a_addr !== 5'd6 || a_data !== 32'd106) begin
                    failures++; $display("FAIL starve_pipe_after: got %0d/x%0d/%0h want 1/x6/6a", a_req, a_addr, a_data); end
            end
        end
    endtask

    task automatic test_full_fifo();
        cycle(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd0, 5'd0);
        cycle(0, 1, 5'd10, 32'd1, 1, 5'd12, 32'hA, 5'd0, 5'd0);
        cycle(0, 1, 5'd10, 32'd2, 1, 5'd13, 32'hB, 5'd0, 5'd0);
        checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL full_ready_one: got %0d want 1", a_ready); end
        cycle(0, 1, 5'd10, 32'd3, 0, 5'd0, 32'd0, 5'd0, 5'd0);
        checks++; if (a_ready !== 1'b0) begin failures++; $display("FAIL full_ready_low: got %0d want 0", a_ready); end
        cycle(0, 1, 5'd10, 32'd4, 0, 5'd0, 32'd0, 5'd0, 5'd0);
        checks++; if (a_stall !== 1'b1) begin failures++; $display("FAIL full_forced_stall: got %0d want 1", a_stall); end
        checks++; if (a_req !== 1'b1 || a_addr !== 5'd12 || a_data !== 32'hA) begin
            failures++; $display("FAIL full_forced_wr: got %0d/x%0d/%0h want 1/x12/a", a_req, a_addr, a_data); end
        idle(5'd0);
        checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL full_ready_back: got %0d want 1", a_ready); end
        checks++; if (a_req !== 1'b1 || a_addr !== 5'd13 || a_data !== 32'hB) begin
            failures++; $display("FAIL full_second_wr: got %0d/x%0d/%0h want 1/x13/b", a_req, a_addr, a_data); end
    endtask

    task automatic test_waw_kill();
        // Buffered MDU x3 killed by a later pipe write to x3.
        cycle(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd0, 5'd0);
        cycle(0, 1, 5'd4, 32'd7, 1, 5'd3, 32'd1, 5'd3, 5'd0);
        cycle(0, 1, 5'd3, 32'd2, 0, 5'd0, 32'd0, 5'd3, 5'd0);
        checks++; if (a_pend1 !== 1'b1) begin failures++; $display("FAIL waw_pend_before: got %0d want 1", a_pend1); end
        checks++; if (a_req !== 1'b1 || a_addr !== 5'd3 || a_data !== 32'd2) begin
            failures++; $display("FAIL waw_pipe_wr: got %0d/x%0d/%0h want 1/x3/2", a_req, a_addr, a_data); end
        for (int i = 0; i < 4; i++) begin
            idle(5'd3);
            checks++; if (a_req !== 1'b0) begin
                failures++; $display("FAIL waw_stale_wr[%0d]: got %0d/x%0d/%0h want no write", i, a_req, a_addr, a_data); end
        end
        checks++; if (a_pend1 !== 1'b0) begin failures++; $display("FAIL waw_pend_after: got %0d want 0", a_pend1); end
        cycle(0, 1, 5'd4, 32'd8, 1, 5'd5, 32'd9, 5'd0, 5'd0);
        cycle(0, 1, 5'd4, 32'd8, 0, 5'd0, 32'd0, 5'd0, 5'd0);
        checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL waw_count_zero: got ready %0d want 1", a_ready); end
        // Same again with the MDU push in the killing cycle.
        cycle(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd0, 5'd0);
        cycle(0, 1, 5'd3, 32'd2, 1, 5'd3, 32'd1, 5'd0, 5'd0);
        checks++; if (a_req !== 1'b1 || a_addr !== 5'd3 || a_data !== 32'd2) begin
            failures++; $display("FAIL waw_same_pipe_wr: got %0d/x%0d/%0h want 1/x3/2", a_req, a_addr, a_data); end
        idle(5'd0);
        checks++; if (a_req !== 1'b0) begin failures++; $display("FAIL waw_same_stale_wr: got %0d/x%0d want no write", a_req, a_addr); end
        cycle(0, 1, 5'd4, 32'd8, 1, 5'd5, 32'd9, 5'd0, 5'd0);
        cycle(0, 1, 5'd4, 32'd8, 0, 5'd0, 32'd0, 5'd0, 5'd0);
        checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL waw_same_count_zero: got ready %0d want 1", a_ready); end
    endtask

    task automatic test_x0_and_reset();
        cycle(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd0, 5'd0);
        cycle(0, 1, 5'd0, 32'h55, 1, 5'd0, 32'h66, 5'd0, 5'd0);
        checks++; if (a_stall !== 1'b0) begin failures++; $display("FAIL x0_stall: got %0d want 0", a_stall); end
        checks++; if (a_req !== 1'b0) begin failures++; $display("FAIL x0_pipe_wr: got %0d want 0", a_req); end
        idle(5'd0);
        checks++; if (a_req !== 1'b0) begin failures++; $display("FAIL x0_mdu_wr: got %0d want 0", a_req); end
        cycle(0, 1, 5'd20, 32'd1, 1, 5'd21, 32'd2, 5'd0, 5'd0);
        cycle(0, 1, 5'd20, 32'd3, 1, 5'd22, 32'd4, 5'd0, 5'd0);
        cycle(1, 1, 5'd20, 32'd5, 0, 5'd0, 32'd0, 5'd21, 5'd22);
        checks++; if (a_req !== 1'b0) begin failures++; $display("FAIL rst_mid_wr: got %0d want 0", a_req); end
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd21, 5'd22);
            checks++; if (a_req !== 1'b0 || a_pend1 !== 1'b0 || a_pend2 !== 1'b0 || a_ready !== 1'b1) begin
                failures++; $display("FAIL rst_mid_after[%0d]: got req%0d pend%0d%0d rdy%0d want 0 00 1",
                                     i, a_req, a_pend1, a_pend2, a_ready); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(99) < 2, $urandom_range(99) < 65, 5'($urandom_range(7)), $urandom,
                  $urandom_range(99) < 40, 5'($urandom_range(7)), $urandom,
                  5'($urandom_range(7)), 5'($urandom_range(7)));
            if (!rst) begin
                checks++; if (a_stall !== e_stall) begin failures++; $display("FAIL rand_stall[%0d]: got %0d want %0d", i, a_stall, e_stall); end
                checks++; if (a_ready !== e_ready) begin failures++; $display("FAIL rand_ready[%0d]: got %0d want %0d", i, a_ready, e_ready); end
                checks++; if (a_pend1 !== e_pend1) begin failures++; $display("FAIL rand_pend1[%0d]: got %0d want %0d", i, a_pend1, e_pend1); end
                checks++; if (a_pend2 !== e_pend2) begin failures++; $display("FAIL rand_pend2[%0d]: got %0d want %0d", i, a_pend2, e_pend2); end
            end
            checks++; if (a_req !== m_req || a_addr !== m_addr || a_data !== m_data) begin
                failures++; $display("FAIL rand_rf[%0d]: got %0d/x%0d/%0h want %0d/x%0d/%0h",
                                     i, a_req, a_addr, a_data, m_req, m_addr, m_data); end
        end
    endtask

    initial begin
        test_reset();
        test_pipe_only();
        test_mdu_idle();
        test_starvation();
        test_full_fifo();
        test_waw_kill();
        test_x0_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
